// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
// State encoding plus the fixed SPI mode (CPOL/CPHA).
package spi_pkg;

  typedef enum logic [1:0] {
    SLV_IDLE,
    SLV_SHIFT,
    SLV_RELOAD
  } spi_slv_state_t;

  localparam int SPI_MODE = 0;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser followed by one edge-detect flop.
// Reports the synchronised level and single-cycle rise/fall strobes.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder with oversampled SCK/SS/MOSI and tx holding reg.
// Optional sticky tx-underrun flag: define SPI_SLAVE_OVERRUN_EN.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              SPI_reset,
  input  logic              SPI_sck,
  input  logic              SPI_ss,
  input  logic              SPI_mosi,
  output logic              SPI_miso,
  input  logic              SPI_MSB,
  input  logic [DATA_W-1:0] SPI_data_tx,
  input  logic              SPI_tx_valid,
  output logic              SPI_tx_ready,
  output logic [DATA_W-1:0] SPI_data_rx,
  output logic              SPI_rx_valid,
  output logic              SPI_flag
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  output logic              SPI_overrun
`endif
);

  localparam int   CNT_W    = $clog2(DATA_W);
  localparam logic SCK_IDLE = 1'((SPI_MODE >> 1) & 1);

  spi_slv_state_t state_q, state_d;

  logic              sck_lvl, sck_rise, sck_fall;
  logic              ss_lvl, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
  logic              mosi_lvl;

  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              msb_q, msb_d;
  logic              miso_q, miso_d;
  logic              flag_q, flag_d;
  logic              rx_valid_q, rx_valid_d;
  logic              pend_q, pend_d;

  logic [DATA_W-1:0] hold_src, tx_next, rx_next;
  logic              last_bit, consume, load;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SCK_IDLE)) u_sck (
    .clk   (clk),
    .rst   (SPI_reset),
    .din   (SPI_sck),
    .level (sck_lvl),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk   (clk),
    .rst   (SPI_reset),
    .din   (SPI_ss),
    .level (ss_lvl),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  assign mosi_d   = {mosi_q[SYNC_STAGES-2:0], SPI_mosi};
  assign mosi_lvl = mosi_q[SYNC_STAGES-1];

  assign hold_src = hold_full_q ? hold_q : '0;
  assign last_bit = bit_cnt_q == CNT_W'(DATA_W - 1);
  assign tx_next  = msb_q ? (tx_sh_q << 1) : (tx_sh_q >> 1);
  assign rx_next  = msb_q ? {rx_sh_q[DATA_W-2:0], mosi_lvl}
                          : {mosi_lvl, rx_sh_q[DATA_W-1:1]};
  assign consume  = (state_q == SLV_IDLE && ss_fall)
                  || state_q == SLV_RELOAD;
  assign load     = SPI_tx_valid & ~hold_full_q;

  always_ff @(posedge clk) begin
    if (SPI_reset) begin
      state_q     <= SLV_IDLE;
      mosi_q      <= '0;
      bit_cnt_q   <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      msb_q       <= 1'b1;
      miso_q      <= 1'b0;
      flag_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mosi_q      <= mosi_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      msb_q       <= msb_d;
      miso_q      <= miso_d;
      flag_q      <= flag_d;
      rx_valid_q  <= rx_valid_d;
      pend_q      <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SLV_IDLE:   if (ss_fall) state_d = SLV_SHIFT;
      SLV_SHIFT:  if (sck_rise && last_bit) state_d = SLV_RELOAD;
      SLV_RELOAD: state_d = SLV_SHIFT;
      default:    state_d = SLV_IDLE;
    endcase
    if (ss_rise) state_d = SLV_IDLE;
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    msb_d       = msb_q;
    miso_d      = miso_q;
    flag_d      = flag_q;
    rx_valid_d  = 1'b0;
    pend_d      = pend_q;
    hold_d      = load ? SPI_data_tx : hold_q;
    hold_full_d = load | (hold_full_q & ~consume);
    unique case (state_q)
      SLV_IDLE: begin
        miso_d    = 1'b0;
        bit_cnt_d = '0;
        if (ss_fall) begin
          msb_d   = SPI_MSB;
          tx_sh_d = hold_src;
          rx_sh_d = '0;
          pend_d  = 1'b0;
          flag_d  = 1'b1;
          miso_d  = SPI_MSB ? hold_src[DATA_W-1] : hold_src[0];
        end
      end
      SLV_SHIFT: begin
        if (sck_rise) begin
          rx_sh_d   = rx_next;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (last_bit) begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
          end
        end else if (sck_fall) begin
          // after a reload the new first bit is already in place
          if (pend_q) begin
            pend_d = 1'b0;
            miso_d = msb_q ? tx_sh_q[DATA_W-1] : tx_sh_q[0];
          end else begin
            tx_sh_d = tx_next;
            miso_d  = msb_q ? tx_next[DATA_W-1] : tx_next[0];
          end
        end
      end
      SLV_RELOAD: begin
        tx_sh_d   = hold_src;
        rx_sh_d   = '0;
        bit_cnt_d = '0;
        pend_d    = 1'b1;
      end
      default: ;
    endcase
    if (ss_rise) begin
      miso_d = 1'b0;
      flag_d = 1'b0;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic under_q, under_d;
  logic ovr_q, ovr_d;

  always_comb begin
    under_d = consume ? ~hold_full_q : under_q;
    ovr_d   = ovr_q & ~load;
    if (rx_valid_d && under_q) ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (SPI_reset) begin
      under_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      under_q <= under_d;
      ovr_q   <= ovr_d;
    end
  end

  assign SPI_overrun = ovr_q;
`endif

  assign SPI_miso     = miso_q;
  assign SPI_tx_ready = ~hold_full_q;
  assign SPI_data_rx  = rx_data_q;
  assign SPI_rx_valid = rx_valid_q;
  assign SPI_flag     = flag_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed plus randomized bench for spi_slave acting as an SPI master.
// Expected bytes come from a tx holding-register model and sent bytes.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       SPI_reset;
  logic       SPI_sck;
  logic       SPI_ss;
  logic       SPI_mosi;
  logic       SPI_miso;
  logic       SPI_MSB;
  logic [7:0] SPI_data_tx;
  logic       SPI_tx_valid;
  logic       SPI_tx_ready;
  logic [7:0] SPI_data_rx;
  logic       SPI_rx_valid;
  logic       SPI_flag;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic       SPI_overrun;
`endif

  int errors = 0;
  int checks = 0;

  int         rx_pulses = 0;
  logic [7:0] rx_q[$];

  logic [7:0] hold_m = 8'h00;
  bit         hold_full_m = 1'b0;

  always #5 clk = ~clk;

  spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .SPI_reset    (SPI_reset),
    .SPI_sck      (SPI_sck),
    .SPI_ss       (SPI_ss),
    .SPI_mosi     (SPI_mosi),
    .SPI_miso     (SPI_miso),
    .SPI_MSB      (SPI_MSB),
    .SPI_data_tx  (SPI_data_tx),
    .SPI_tx_valid (SPI_tx_valid),
    .SPI_tx_ready (SPI_tx_ready),
    .SPI_data_rx  (SPI_data_rx),
    .SPI_rx_valid (SPI_rx_valid),
    .SPI_flag     (SPI_flag)
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    .SPI_overrun  (SPI_overrun)
`endif
  );

  always @(negedge clk) begin
    if (SPI_rx_valid === 1'b1) begin
      rx_pulses++;
      rx_q.push_back(SPI_data_rx);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] b);
    int n = 0;
    while (SPI_tx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("load_ready", {31'd0, SPI_tx_ready}, 32'd1);
    SPI_data_tx  = b;
    SPI_tx_valid = 1'b1;
    @(negedge clk);
    SPI_tx_valid = 1'b0;
    hold_m      = b;
    hold_full_m = 1'b1;
  endtask

  // Byte the slave should send when a frame begins now.
  function automatic logic [7:0] take_tx();
    logic [7:0] b = hold_full_m ? hold_m : 8'h00;
    hold_full_m = 1'b0;
    return b;
  endfunction

  task automatic xfer(input logic [7:0] mo, input bit msb,
                      input int nbits, output logic [7:0] mi);
    int idx;
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      idx = msb ? 7 - i : i;
      SPI_mosi = mo[idx];
      clks(4);
      mi[idx] = SPI_miso;
      SPI_sck = 1'b1;
      clks(4);
      SPI_sck = 1'b0;
    end
  endtask

  task automatic ss_low(input bit msb);
    SPI_MSB = msb;
    SPI_ss  = 1'b0;
    clks(6);
  endtask

  task automatic ss_high();
    clks(6);
    SPI_ss   = 1'b1;
    SPI_mosi = 1'b0;
    clks(6);
  endtask

  task automatic frame(input string tag, input bit msb,
                       input logic [7:0] mo);
    logic [7:0] exp_tx, mi;
    int p0 = rx_pulses;
    ss_low(msb);
    exp_tx = take_tx();
    check({tag, "_flag"}, {31'd0, SPI_flag}, 32'd1);
    xfer(mo, msb, 8, mi);
    ss_high();
    check({tag, "_miso"}, {24'd0, mi}, {24'd0, exp_tx});
    check({tag, "_pulses"}, rx_pulses - p0, 32'd1);
    check({tag, "_rx"}, {24'd0, SPI_data_rx}, {24'd0, mo});
    if (rx_q.size() > 0)
      check({tag, "_rxq"}, {24'd0, rx_q.pop_front()}, {24'd0, mo});
    check({tag, "_idle"}, {30'd0, SPI_flag, SPI_miso}, 32'd0);
  endtask

  initial begin
    logic [7:0] mi, mi2, prev_rx;
    logic [7:0] e1, e2, mo;
    int p0, bad;
    bit msb;

    SPI_reset    = 1'b1;
    SPI_sck      = 1'b0;
    SPI_ss       = 1'b1;
    SPI_mosi     = 1'b0;
    SPI_MSB      = 1'b1;
    SPI_data_tx  = 8'h00;
    SPI_tx_valid = 1'b0;
    clks(5);
    SPI_reset = 1'b0;
    clks(1);

    check("rst_miso", {31'd0, SPI_miso}, 32'd0);
    check("rst_ready", {31'd0, SPI_tx_ready}, 32'd1);
    check("rst_rx", {24'd0, SPI_data_rx}, 32'd0);
    check("rst_valid", {31'd0, SPI_rx_valid}, 32'd0);
    check("rst_flag", {31'd0, SPI_flag}, 32'd0);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("rst_ovr", {31'd0, SPI_overrun}, 32'd0);
`endif

    // 1: idle with SS high
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (SPI_miso !== 1'b0 || SPI_flag !== 1'b0) bad++;
    end
    check("idle_bad", bad, 32'd0);
    check("idle_pulses", rx_pulses, 32'd0);
    check("idle_ready", {31'd0, SPI_tx_ready}, 32'd1);

    // 2: MSB first
    load(8'hA5);
    check("t2_ready_low", {31'd0, SPI_tx_ready}, 32'd0);
    frame("t2", 1'b1, 8'h3C);
    check("t2_ready_back", {31'd0, SPI_tx_ready}, 32'd1);

    // 3: LSB first
    load(8'h01);
    frame("t3", 1'b0, 8'h80);

    // 4: two frames under one SS low
    load(8'h11);
    p0 = rx_pulses;
    ss_low(1'b1);
    e1 = take_tx();
    load(8'h22);
    xfer(8'hC3, 1'b1, 8, mi);
    e2 = take_tx();
    xfer(8'h5E, 1'b1, 8, mi2);
    ss_high();
    check("t4_miso1", {24'd0, mi}, {24'd0, e1});
    check("t4_miso2", {24'd0, mi2}, {24'd0, e2});
    check("t4_pulses", rx_pulses - p0, 32'd2);
    if (rx_q.size() == 2) begin
      check("t4_rx1", {24'd0, rx_q.pop_front()}, 32'hC3);
      check("t4_rx2", {24'd0, rx_q.pop_front()}, 32'h5E);
    end
    check("t4_rx", {24'd0, SPI_data_rx}, 32'h5E);

    // 5: abort after 5 bits
    load(8'h5A);
    prev_rx = SPI_data_rx;
    p0 = rx_pulses;
    ss_low(1'b1);
    void'(take_tx());
    xfer(8'hF0, 1'b1, 5, mi);
    ss_high();
    check("t5_pulses", rx_pulses - p0, 32'd0);
    check("t5_rx_kept", {24'd0, SPI_data_rx}, {24'd0, prev_rx});
    check("t5_flag", {31'd0, SPI_flag}, 32'd0);
    check("t5_ready", {31'd0, SPI_tx_ready}, 32'd1);
    load(8'h96);
    frame("t5_next", 1'b1, 8'h69);

    // 6: underrun
`ifdef SPI_SLAVE_OVERRUN_EN
    check("t6_ovr_pre", {31'd0, SPI_overrun}, 32'd0);
`endif
    check("t6_ready", {31'd0, SPI_tx_ready}, 32'd1);
    frame("t6", 1'b1, 8'hE7);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("t6_ovr_set", {31'd0, SPI_overrun}, 32'd1);
    clks(20);
    check("t6_ovr_sticky", {31'd0, SPI_overrun}, 32'd1);
`endif
    load(8'h77);
`ifdef SPI_SLAVE_OVERRUN_EN
    clks(1);
    check("t6_ovr_clr", {31'd0, SPI_overrun}, 32'd0);
`endif

    // random frames, tx loaded most of the time
    for (int k = 0; k < 10; k++) begin
      msb = 1'($urandom_range(1, 0));
      mo  = 8'($urandom);
      if (!hold_full_m && $urandom_range(3, 0) != 0)
        load(8'($urandom));
      frame($sformatf("rnd%0d", k), msb, mo);
    end

    // reset mid-frame empties the holding register
    load(8'hC5);
    ss_low(1'b1);
    load(8'h3A);
    xfer(8'hFF, 1'b1, 3, mi);
    SPI_reset = 1'b1;
    clks(1);
    SPI_reset = 1'b0;
    hold_full_m = 1'b0;
    check("mid_rst_ready", {31'd0, SPI_tx_ready}, 32'd1);
    check("mid_rst_flag", {31'd0, SPI_flag}, 32'd0);
    check("mid_rst_rx", {24'd0, SPI_data_rx}, 32'd0);
    SPI_ss = 1'b1;
    clks(6);
    frame("post_rst", 1'b0, 8'h4D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
